vga_vram_arbiter: RTL and testbench

Shares one single-port video RAM between the VGA scan-out fetcher and the RISC-V core's memory-mapped frame-buffer port. Display reads normally win, because missing one corrupts the visible picture. CPU reads and writes get priority during blanking, and a bounded-wait guard stops the CPU from starving during active video. The block sits between the 100 MHz system clock domain logic (pixel fetcher, CPU store unit) and the frame-buffer BRAM that feeds the 4:4:4 Red/Green/Blue outputs.

---
 rtl/vga_pkg.sv | 36 +++
 rtl/vram_wait_timer.sv | 41 ++++
 rtl/vga_vram_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_vga_vram_arbiter.sv | 392 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared types and constants for the VGA frame-buffer path.
//   owner_t     : which requester owns an in-flight RAM access.
//   fsm_state_t : arbiter issue-stage state (IDLE / ISSUE_DISP / ISSUE_CPU).
//   S_*         : the same state codes as plain localparam vectors, used by
//                 the arbiter's state register.
//   RGB_W and the 640x480@60 timing constants used by the scan-out logic.
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam int RGB_W = 12;

  localparam int H_TOTAL     = 800;
  localparam int V_TOTAL     = 525;
  localparam int H_SYNC      = 96;
  localparam int V_SYNC      = 2;
  localparam int H_VIS_START = 144;
  localparam int V_VIS_START = 35;

  typedef enum logic {
    OWN_DISP = 1'b0,
    OWN_CPU  = 1'b1
  } owner_t;

  typedef enum logic [1:0] {
    FSM_IDLE       = 2'd0,
    FSM_ISSUE_DISP = 2'd1,
    FSM_ISSUE_CPU  = 2'd2
  } fsm_state_t;

  localparam logic [1:0] S_IDLE       = FSM_IDLE;
  localparam logic [1:0] S_ISSUE_DISP = FSM_ISSUE_DISP;
  localparam logic [1:0] S_ISSUE_CPU  = FSM_ISSUE_CPU;

endpackage

// File: rtl/vram_wait_timer.sv
// -----------------------------------------------------------------------------
// vram_wait_timer
// Saturating count of consecutive cycles in which a pending CPU request lost
// arbitration. When the count reaches MAX_WAIT the CPU is forced to win.
// Ports:
//   clk, rst     : system clock, synchronous active-high reset
//   cpu_valid    : CPU request pending this cycle
//   cpu_ack      : CPU granted this cycle
//   wait_cnt     : current losing-cycle count (saturates at MAX_WAIT)
//   force_cpu    : wait_cnt == MAX_WAIT
// -----------------------------------------------------------------------------
module vram_wait_timer #(
  parameter int MAX_WAIT = 8,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cpu_valid,
  input  logic             cpu_ack,
  output logic [CNT_W-1:0] wait_cnt,
  output logic             force_cpu
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!cpu_valid || cpu_ack) begin
      r_cnt <= '0;
    end else if (r_cnt != MAX_CNT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign wait_cnt  = r_cnt;
  assign force_cpu = (r_cnt == MAX_CNT);

endmodule

// File: rtl/vga_vram_arbiter.sv
// -----------------------------------------------------------------------------
// vga_vram_arbiter
// Shares one single-port frame-buffer RAM between the VGA pixel fetcher and
// the CPU frame-buffer port.
//
// Handshake: a requester raises *_req/*_valid with address (and CPU write
// fields) stable; the cycle in which the combinational *_ack is high is the
// transfer cycle. The requester may drop the request or present a new one on
// the following cycle. Read data comes back on *_rvalid/*_rdata two cycles
// after the ack; *_rvalid is a one-cycle pulse with no back-pressure.
//
// Ports:
//   clk, rst                 : system clock, synchronous active-high reset
//   blank                    : VGA outside visible window
//   disp_req/addr, disp_ack  : display read request / grant
//   disp_rvalid/rdata        : display read return
//   cpu_valid/we/addr/wdata  : CPU request, cpu_ack grant
//   cpu_rvalid/rdata         : CPU read return
//   ram_en/we/addr/wdata     : registered RAM command
//   ram_rdata                : RAM read data, one cycle after a read command
//   dbg_state, dbg_wait_cnt  : issue-stage state and starvation counter
// -----------------------------------------------------------------------------
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W   = 17,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             blank,
  input  logic                             disp_req,
  input  logic [ADDR_W-1:0]                disp_addr,
  output logic                             disp_ack,
  output logic                             disp_rvalid,
  output logic [DATA_W-1:0]                disp_rdata,
  input  logic                             cpu_valid,
  input  logic                             cpu_we,
  input  logic [ADDR_W-1:0]                cpu_addr,
  input  logic [DATA_W-1:0]                cpu_wdata,
  output logic                             cpu_ack,
  output logic                             cpu_rvalid,
  output logic [DATA_W-1:0]                cpu_rdata,
  output logic                             ram_en,
  output logic                             ram_we,
  output logic [ADDR_W-1:0]                ram_addr,
  output logic [DATA_W-1:0]                ram_wdata,
  input  logic [DATA_W-1:0]                ram_rdata,
  output logic [1:0]                       dbg_state,
  output logic [$clog2(MAX_WAIT+1)-1:0]    dbg_wait_cnt
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  logic              w_force;
  logic [WAIT_W-1:0] w_wait_cnt;
  logic              w_cpu_grant;
  logic              w_disp_grant;
  logic [1:0]        w_next_state;

  // CPU wins when starved, during blanking, or when the display is idle.
  // Reset suppresses both grants so nothing is acked that cannot be issued.
  assign w_cpu_grant  = !rst && cpu_valid && (w_force || blank || !disp_req);
  assign w_disp_grant = !rst && disp_req && !w_cpu_grant;

  assign cpu_ack  = w_cpu_grant;
  assign disp_ack = w_disp_grant;

  vram_wait_timer #(
    .MAX_WAIT (MAX_WAIT),
    .CNT_W    (WAIT_W)
  ) u_wait_timer (
    .clk       (clk),
    .rst       (rst),
    .cpu_valid (cpu_valid),
    .cpu_ack   (w_cpu_grant),
    .wait_cnt  (w_wait_cnt),
    .force_cpu (w_force)
  );

  always_comb begin
    w_next_state = S_IDLE;
    if (w_cpu_grant) begin
      w_next_state = S_ISSUE_CPU;
    end else if (w_disp_grant) begin
      w_next_state = S_ISSUE_DISP;
    end
  end

  // ---------------------------------------------------------------------------
  // Issue stage
  // ---------------------------------------------------------------------------
  logic [1:0]        r_state;
  logic              r_ram_en;
  logic              r_ram_we;
  logic [ADDR_W-1:0] r_ram_addr;
  logic [DATA_W-1:0] r_ram_wdata;
  logic              r_rd_pend;
  owner_t            r_own;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ram_en    <= 1'b0;
      r_ram_we    <= 1'b0;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_rd_pend   <= 1'b0;
      r_own       <= OWN_DISP;
    end else begin
      r_state   <= w_next_state;
      r_ram_en  <= w_cpu_grant || w_disp_grant;
      r_ram_we  <= w_cpu_grant && cpu_we;
      r_rd_pend <= w_disp_grant || (w_cpu_grant && !cpu_we);
      // Address/data hold when idle so the RAM pins stay quiet.
      // The display has no write data, so ram_wdata keeps its last value.
      if (w_cpu_grant) begin
        r_ram_addr  <= cpu_addr;
        r_ram_wdata <= cpu_wdata;
        r_own       <= OWN_CPU;
      end else if (w_disp_grant) begin
        r_ram_addr  <= disp_addr;
        r_own       <= OWN_DISP;
      end
    end
  end

  assign ram_en    = r_ram_en;
  assign ram_we    = r_ram_we;
  assign ram_addr  = r_ram_addr;
  assign ram_wdata = r_ram_wdata;
  assign dbg_state    = r_state;
  assign dbg_wait_cnt = w_wait_cnt;

  // ---------------------------------------------------------------------------
  // Return stage
  // ---------------------------------------------------------------------------
  logic              r_ret_valid;
  owner_t            r_ret_own;
  logic [DATA_W-1:0] r_disp_rdata;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic              w_disp_ret;
  logic              w_cpu_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ret_valid <= 1'b0;
      r_ret_own   <= OWN_DISP;
    end else begin
      r_ret_valid <= r_rd_pend;
      r_ret_own   <= r_own;
    end
  end

  assign w_disp_ret = r_ret_valid && (r_ret_own == OWN_DISP);
  assign w_cpu_ret  = r_ret_valid && (r_ret_own == OWN_CPU);

  // ram_rdata is valid in the return cycle itself, so it is forwarded straight
  // out on the rvalid pulse and captured to hold the value afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_disp_rdata <= '0;
      r_cpu_rdata  <= '0;
    end else begin
      if (w_disp_ret) begin
        r_disp_rdata <= ram_rdata;
      end
      if (w_cpu_ret) begin
        r_cpu_rdata <= ram_rdata;
      end
    end
  end

  assign disp_rvalid = w_disp_ret;
  assign cpu_rvalid  = w_cpu_ret;
  assign disp_rdata  = w_disp_ret ? ram_rdata : r_disp_rdata;
  assign cpu_rdata   = w_cpu_ret  ? ram_rdata : r_cpu_rdata;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
module tb_vga_vram_arbiter;

  localparam int ADDR_W   = 17;
  localparam int DATA_W   = 12;
  localparam int MAX_WAIT = 4;
  localparam int WAIT_W   = $clog2(MAX_WAIT + 1);

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              blank = 1'b0;
  logic              disp_req = 1'b0;
  logic [ADDR_W-1:0] disp_addr = '0;
  logic              disp_ack;
  logic              disp_rvalid;
  logic [DATA_W-1:0] disp_rdata;
  logic              cpu_valid = 1'b0;
  logic              cpu_we = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic              cpu_ack;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;
  logic [1:0]        dbg_state;
  logic [WAIT_W-1:0] dbg_wait_cnt;

  always #5 clk = ~clk;

  vga_vram_arbiter #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .MAX_WAIT (MAX_WAIT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .blank        (blank),
    .disp_req     (disp_req),
    .disp_addr    (disp_addr),
    .disp_ack     (disp_ack),
    .disp_rvalid  (disp_rvalid),
    .disp_rdata   (disp_rdata),
    .cpu_valid    (cpu_valid),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_ack      (cpu_ack),
    .cpu_rvalid   (cpu_rvalid),
    .cpu_rdata    (cpu_rdata),
    .ram_en       (ram_en),
    .ram_we       (ram_we),
    .ram_addr     (ram_addr),
    .ram_wdata    (ram_wdata),
    .ram_rdata    (ram_rdata),
    .dbg_state    (dbg_state),
    .dbg_wait_cnt (dbg_wait_cnt)
  );

  // ---------------------------------------------------------------------------
  // Frame-buffer RAM (environment): synchronous read, one cycle latency
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] mem [int];

  function automatic logic [DATA_W-1:0] default_word(int a);
    return DATA_W'((a * 7) ^ 12'h5A5);
  endfunction

  function automatic logic [DATA_W-1:0] mem_lookup(int a);
    if (mem.exists(a)) return mem[a];
    return default_word(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else        ram_rdata <= mem_lookup(int'(ram_addr));
    end
  end

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    blank = 1'b0; disp_req = 1'b0; cpu_valid = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic drain();
    idle_inputs();
    repeat (3) tick();
  endtask

  // Table vectors: {rst, blank, disp_req, cpu_valid, cpu_we, exp_disp_ack, exp_cpu_ack}
  typedef struct packed {
    logic rst, blank, disp_req, cpu_valid, cpu_we, exp_disp_ack, exp_cpu_ack;
  } vec_t;
  vec_t vecs [11];

  // Reference model state for the random phase
  typedef struct {
    int               due;
    bit               is_cpu;
    logic [DATA_W-1:0] data;
  } ret_t;
  ret_t              ret_q[$];
  logic [DATA_W-1:0] model_mem [int];

  function automatic logic [DATA_W-1:0] model_read(int a);
    if (model_mem.exists(a)) return model_mem[a];
    return default_word(a);
  endfunction

  initial begin
    logic [DATA_W-1:0] last_stream;
    mem[32'h100] = 12'hABC;
    mem[32'h200] = 12'h123;

    vecs[0]  = 7'b0_0_0_0_0_0_0;
    vecs[1]  = 7'b0_0_1_0_0_1_0;
    vecs[2]  = 7'b0_0_0_1_0_0_1;
    vecs[3]  = 7'b0_0_1_1_0_1_0;
    vecs[4]  = 7'b0_0_1_1_1_1_0;
    vecs[5]  = 7'b0_1_1_1_0_0_1;
    vecs[6]  = 7'b0_1_1_0_0_1_0;
    vecs[7]  = 7'b0_1_0_1_1_0_1;
    vecs[8]  = 7'b1_0_1_0_0_0_0;
    vecs[9]  = 7'b1_1_1_1_0_0_0;
    vecs[10] = 7'b1_0_0_1_1_0_0;

    // ---- reset state ----
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_ram_en", ram_en, 0);
    check("rst_ram_we", ram_we, 0);
    check("rst_ram_addr", ram_addr, 0);
    check("rst_ram_wdata", ram_wdata, 0);
    check("rst_disp_rvalid", disp_rvalid, 0);
    check("rst_cpu_rvalid", cpu_rvalid, 0);
    check("rst_disp_rdata", disp_rdata, 0);
    check("rst_cpu_rdata", cpu_rdata, 0);
    check("rst_state", dbg_state, 0);
    check("rst_wait", dbg_wait_cnt, 0);
    tick();

    // ---- table: single-cycle grant decisions from a clean counter ----
    for (int i = 0; i < 11; i++) begin
      rst = vecs[i].rst; blank = vecs[i].blank; disp_req = vecs[i].disp_req;
      cpu_valid = vecs[i].cpu_valid; cpu_we = vecs[i].cpu_we;
      #1;
      check($sformatf("vec%0d_disp_ack", i), disp_ack, vecs[i].exp_disp_ack);
      check($sformatf("vec%0d_cpu_ack", i), cpu_ack, vecs[i].exp_cpu_ack);
      rst = 1'b0;
      idle_inputs();
      tick();
    end
    drain();

    // ---- CPU write, display idle ----
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00010; cpu_wdata = 12'hF0F;
    #1;
    check("cw_cpu_ack", cpu_ack, 1);
    check("cw_disp_ack", disp_ack, 0);
    tick();
    idle_inputs();
    #1;
    check("cw_ram_en", ram_en, 1);
    check("cw_ram_we", ram_we, 1);
    check("cw_ram_addr", ram_addr, 17'h00010);
    check("cw_ram_wdata", ram_wdata, 12'hF0F);
    tick();
    #1;
    check("cw_no_rvalid", cpu_rvalid, 0);
    check("cw_ram_idle", ram_en, 0);
    drain();

    // ---- simultaneous reads ----
    disp_req = 1'b1; disp_addr = 17'h00100;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00200;
    #1;
    check("sr_disp_ack", disp_ack, 1);
    check("sr_cpu_ack0", cpu_ack, 0);
    tick();
    disp_req = 1'b0;
    #1;
    check("sr_cpu_ack1", cpu_ack, 1);
    check("sr_ram_addr0", ram_addr, 17'h00100);
    check("sr_ram_we0", ram_we, 0);
    tick();
    cpu_valid = 1'b0;
    #1;
    check("sr_disp_rvalid", disp_rvalid, 1);
    check("sr_disp_rdata", disp_rdata, 12'hABC);
    check("sr_cpu_rvalid_early", cpu_rvalid, 0);
    check("sr_ram_addr1", ram_addr, 17'h00200);
    tick();
    #1;
    check("sr_cpu_rvalid", cpu_rvalid, 1);
    check("sr_cpu_rdata", cpu_rdata, 12'h123);
    check("sr_disp_rvalid_off", disp_rvalid, 0);
    check("sr_disp_rdata_hold", disp_rdata, 12'hABC);
    tick();
    #1;
    check("sr_cpu_rdata_hold", cpu_rdata, 12'h123);
    drain();

    // ---- starvation guard ----
    disp_req = 1'b1; disp_addr = 17'h00300;
    cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h00301;
    for (int k = 0; k <= MAX_WAIT; k++) begin
      #1;
      check($sformatf("sv%0d_wait", k), dbg_wait_cnt, k);
      check($sformatf("sv%0d_disp_ack", k), disp_ack, (k < MAX_WAIT) ? 1 : 0);
      check($sformatf("sv%0d_cpu_ack", k), cpu_ack, (k == MAX_WAIT) ? 1 : 0);
      tick();
      if (k == MAX_WAIT) cpu_valid = 1'b0;
      disp_addr = disp_addr + 1'b1;
    end
    #1;
    check("sv_wait_clear", dbg_wait_cnt, 0);
    drain();

    // ---- blanking priority ----
    blank = 1'b1; disp_req = 1'b1; disp_addr = 17'h00500;
    cpu_valid = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h00020; cpu_wdata = 12'h0AA;
    #1;
    check("bl_cpu_ack", cpu_ack, 1);
    check("bl_disp_ack", disp_ack, 0);
    tick();
    blank = 1'b0; cpu_addr = 17'h00021;
    #1;
    check("bl_unblank_disp_ack", disp_ack, 1);
    check("bl_unblank_cpu_ack", cpu_ack, 0);
    tick();
    drain();

    // ---- reset mid-read ----
    disp_req = 1'b1; disp_addr = 17'h00100;
    #1;
    check("rm_disp_ack", disp_ack, 1);
    tick();
    rst = 1'b1; cpu_valid = 1'b1; cpu_we = 1'b0;
    #1;
    check("rm_disp_ack_in_rst", disp_ack, 0);
    check("rm_cpu_ack_in_rst", cpu_ack, 0);
    check("rm_ram_en_issue", ram_en, 1);
    tick();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rm_disp_rvalid", disp_rvalid, 0);
    check("rm_cpu_rvalid", cpu_rvalid, 0);
    check("rm_ram_en", ram_en, 0);
    check("rm_ram_addr", ram_addr, 0);
    check("rm_ram_wdata", ram_wdata, 0);
    check("rm_disp_rdata", disp_rdata, 0);
    check("rm_cpu_rdata", cpu_rdata, 0);
    check("rm_state", dbg_state, 0);
    tick();
    #1;
    check("rm_disp_rvalid_late", disp_rvalid, 0);
    drain();

    // ---- streaming: 16 back-to-back display reads ----
    last_stream = '0;
    for (int c = 0; c < 18; c++) begin
      if (c < 16) begin
        disp_req = 1'b1; disp_addr = ADDR_W'(17'h00400 + c);
      end else begin
        disp_req = 1'b0;
      end
      #1;
      if (c < 16) begin
        check($sformatf("st%0d_ack", c), disp_ack, 1);
        exp_q.push_back(mem_lookup(32'h400 + c));
      end
      if (c >= 2) begin
        check($sformatf("st%0d_rvalid", c), disp_rvalid, 1);
        if (exp_q.size() > 0) begin
          last_stream = exp_q.pop_front();
          check($sformatf("st%0d_rdata", c), disp_rdata, last_stream);
        end
      end
      tick();
    end
    #1;
    check("st_end_rvalid", disp_rvalid, 0);
    tick();

    // ---- randomized traffic against the reference model ----
    begin
      int                m_wait;
      bit                e_disp, e_cpu, e_dv, e_cv;
      bit                p_en, p_we;
      logic [ADDR_W-1:0] p_addr;
      logic [DATA_W-1:0] p_wdata;
      logic [DATA_W-1:0] last_disp, last_cpu;
      bit                d_ack_prev, c_ack_prev;
      ret_t              r;

      model_mem  = mem;
      m_wait     = 0;
      p_en       = 0; p_we = 0; p_addr = 17'h0040F; p_wdata = '0;
      last_disp  = last_stream;
      last_cpu   = '0;
      d_ack_prev = 0; c_ack_prev = 0;

      for (int cyc = 0; cyc < 400; cyc++) begin
        if (!disp_req || d_ack_prev) begin
          disp_req  = ($urandom_range(0, 99) < 60);
          disp_addr = ADDR_W'($urandom_range(0, 31));
        end
        if (!cpu_valid || c_ack_prev) begin
          cpu_valid = ($urandom_range(0, 99) < 50);
          cpu_we    = $urandom_range(0, 1) == 1;
          cpu_addr  = ADDR_W'($urandom_range(0, 31));
          cpu_wdata = DATA_W'($urandom);
        end
        blank = ($urandom_range(0, 9) < 3);
        #1;

        // Priority list, first match wins
        e_disp = 0; e_cpu = 0;
        if (cpu_valid && m_wait == MAX_WAIT) e_cpu = 1;
        else if (blank && cpu_valid)         e_cpu = 1;
        else if (disp_req)                   e_disp = 1;
        else if (cpu_valid)                  e_cpu = 1;

        check("rnd_disp_ack", disp_ack, e_disp);
        check("rnd_cpu_ack", cpu_ack, e_cpu);
        check("rnd_ram_en", ram_en, p_en);
        check("rnd_ram_we", ram_we, p_we);
        check("rnd_ram_addr", ram_addr, p_addr);
        if (p_we) check("rnd_ram_wdata", ram_wdata, p_wdata);

        e_dv = 0; e_cv = 0;
        if (ret_q.size() > 0 && ret_q[0].due == cyc) begin
          r = ret_q.pop_front();
          if (r.is_cpu) begin e_cv = 1; last_cpu = r.data; end
          else          begin e_dv = 1; last_disp = r.data; end
        end
        check("rnd_disp_rvalid", disp_rvalid, e_dv);
        check("rnd_cpu_rvalid", cpu_rvalid, e_cv);
        check("rnd_disp_rdata", disp_rdata, last_disp);
        check("rnd_cpu_rdata", cpu_rdata, last_cpu);

        d_ack_prev = disp_ack;
        c_ack_prev = cpu_ack;
        p_en = e_disp || e_cpu;
        p_we = e_cpu && cpu_we;
        if (e_cpu) begin
          p_addr  = cpu_addr;
          p_wdata = cpu_wdata;
          if (cpu_we) model_mem[int'(cpu_addr)] = cpu_wdata;
          else        ret_q.push_back('{cyc + 2, 1'b1, model_read(int'(cpu_addr))});
        end else if (e_disp) begin
          p_addr = disp_addr;
          ret_q.push_back('{cyc + 2, 1'b0, model_read(int'(disp_addr))});
        end
        if (cpu_valid && !e_cpu) m_wait = (m_wait < MAX_WAIT) ? m_wait + 1 : m_wait;
        else                     m_wait = 0;
        tick();
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
